msg_stream_generator: RTL

Parametrised test-message source for the AES datapath. On a start pulse it emits a burst of one or more packetised messages on a valid/ready stream with sop/eop/empty framing. Any byte length is supported, with four data patterns and a programmable inter-message gap. It drives cipher-core inputs in simulation and on-chip self-test, replacing the fixed-length, all-zero word source.

---
 rtl/msg_stream_generator.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/msg_stream_generator.sv
// Test-message source: bursts of framed messages (sop/eop/empty) with selectable data pattern and gap.
// First beat one cycle after start; all outputs registered and held stable while valid & !ready.
module msg_stream_generator #(
  parameter int DATA_W  = 128,
  parameter int LEN_W   = 16,
  parameter int EMPTY_W = $clog2(DATA_W/8)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [7:0]         cfg_msg_cnt,
  input  logic [7:0]         cfg_gap,
  input  logic [1:0]         cfg_mode,
  input  logic [31:0]        cfg_seed,
  output logic               busy,
  output logic               done,
  output logic               msg_out_valid,
  output logic [DATA_W-1:0]  msg_out_data,
  output logic               msg_out_sop,
  output logic               msg_out_eop,
  output logic [EMPTY_W-1:0] msg_out_empty,
  input  logic               msg_out_ready
);

  localparam int               LANES     = DATA_W / 32;
  localparam int               BPB       = DATA_W / 8;
  localparam logic [LEN_W-1:0] BPB_L     = LEN_W'(BPB);
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         gap_q, gap_d;
  logic [1:0]         mode_q, mode_d;
  logic [31:0]        seed_q, seed_d;
  logic [7:0]         msg_idx_q, msg_idx_d;
  logic [LEN_W-1:0]   word_idx_q, word_idx_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic               abort_seen_q, abort_seen_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;

  logic               load_out;
  logic [31:0]        lane;
  logic [15:0]        widx16;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    msg_idx_d    = msg_idx_q;
    word_idx_d   = word_idx_q;
    rem_d        = rem_q;
    lfsr_d       = lfsr_q;
    gap_cnt_d    = gap_cnt_q;
    abort_seen_d = abort_seen_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_out     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (cfg_len != '0) && (cfg_msg_cnt != 8'd0) && !abort) begin
          len_d        = cfg_len;
          cnt_d        = cfg_msg_cnt;
          gap_d        = cfg_gap;
          mode_d       = cfg_mode;
          seed_d       = cfg_seed;
          msg_idx_d    = 8'd0;
          word_idx_d   = '0;
          rem_d        = cfg_len;
          lfsr_d       = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
          abort_seen_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_SEND;
          load_out     = 1'b1;
        end
      end
      S_SEND: begin
        if (abort) abort_seen_d = 1'b1;
        if (msg_out_ready) begin
          load_out = 1'b1;
          lfsr_d   = lfsr_step(lfsr_q);
          if (eop_q) begin
            msg_idx_d    = msg_idx_q + 8'd1;
            word_idx_d   = '0;
            rem_d        = len_q;
            abort_seen_d = 1'b0;
            // An abort arriving on the eop handshake itself still ends the burst here.
            if ((msg_idx_q == cnt_q - 8'd1) || abort_seen_q || abort) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q != 8'd0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            rem_d      = rem_q - BPB_L;
            word_idx_d = word_idx_q + LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          load_out = 1'b1;
        end else if (gap_cnt_q <= 8'd1) begin
          state_d  = S_SEND;
          load_out = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers only reload on a state/beat change so a stalled beat holds.
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    widx16  = 16'(word_idx_d);
    lane    = 32'd0;
    if (load_out) begin
      valid_d = 1'b0;
      data_d  = '0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      empty_d = '0;
      if (state_d == S_SEND) begin
        case (mode_d)
          2'd0:    lane = 32'd0;
          2'd1:    lane = {msg_idx_d, 8'h00, widx16};
          2'd2:    lane = lfsr_d;
          default: lane = seed_d;
        endcase
        valid_d = 1'b1;
        data_d  = {LANES{lane}};
        sop_d   = (word_idx_d == '0);
        eop_d   = (rem_d <= BPB_L);
        empty_d = eop_d ? EMPTY_W'(BPB_L - rem_d) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      mode_q       <= '0;
      seed_q       <= '0;
      msg_idx_q    <= '0;
      word_idx_q   <= '0;
      rem_q        <= '0;
      lfsr_q       <= '0;
      gap_cnt_q    <= '0;
      abort_seen_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      msg_idx_q    <= msg_idx_d;
      word_idx_q   <= word_idx_d;
      rem_q        <= rem_d;
      lfsr_q       <= lfsr_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_seen_q <= abort_seen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      empty_q      <= empty_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign msg_out_valid = valid_q;
  assign msg_out_data  = data_q;
  assign msg_out_sop   = sop_q;
  assign msg_out_eop   = eop_q;
  assign msg_out_empty = empty_q;

endmodule
